// File: rtl/siganfu_pkg.sv
// siganfu_pkg: state encodings, firing-mode constants and helpers shared by the weapon controller
package siganfu_pkg;
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SHOOT_SINGLE = 3'd1,
    SHOOT_AUTO   = 3'd2,
    RELOAD       = 3'd3,
    OVERHEAT     = 3'd4,
    DOWNFALL     = 3'd5,
    SHOOT_BURST  = 3'd6
  } state_t;
  typedef enum logic [1:0] {T_IDLE, T_PULSE, T_GAP} tphase_t;
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  function automatic state_t shoot_state(input logic [1:0] m);
    return m == MODE_SINGLE ? SHOOT_SINGLE :
           m == MODE_BURST  ? SHOOT_BURST  :
           m == MODE_AUTO   ? SHOOT_AUTO   : SHOOT_SINGLE;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/siganfu_shot_timer.sv
// siganfu_shot_timer: one shot is fire high PULSE_CYC cycles then low GAP_CYC cycles; done marks the last gap cycle
module siganfu_shot_timer
  import siganfu_pkg::*;
#(
  parameter int PULSE_CYC = 5,
  parameter int GAP_CYC   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic fire,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2((PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC) + 1);
  tphase_t phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fire_q, fire_d, last;
  always_comb begin
    busy = phase_q != T_IDLE;
    last = cnt_q == CW'(phase_q == T_PULSE ? PULSE_CYC - 1 : GAP_CYC - 1);
    done = phase_q == T_GAP && last;
    phase_d = phase_q;
    cnt_d = (busy && !last) ? cnt_q + 1'b1 : '0;
    fire_d = fire_q;
    if (abort) begin
      phase_d = T_IDLE;
      cnt_d = '0;
      fire_d = 1'b0;
    end else if (start) begin
      phase_d = T_PULSE;
      cnt_d = '0;
      fire_d = 1'b1;
    end else if (busy && last) begin
      phase_d = phase_q == T_PULSE ? T_GAP : T_IDLE;
      fire_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= T_IDLE;
      cnt_q <= '0;
      fire_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      fire_q <= fire_d;
    end
  end
  assign fire = fire_q;
endmodule

// File: rtl/siganfu_weapon_ctrl.sv
// siganfu_weapon_ctrl: turret fire-control FSM with magazines, reload, overheat and downfall handling.
// Defining SIGANFU_SHOT_COUNTER_EN adds a saturating 16-bit shots_total output.
module siganfu_weapon_ctrl
  import siganfu_pkg::*;
#(
  parameter int MAG_SIZE   = 25,
  parameter int SPARE_MAGS = 3,
  parameter int BURST_LEN  = 3,
  parameter int PULSE_CYC  = 5,
  parameter int GAP_CYC    = 5,
  parameter int RELOAD_CYC = 50,
  parameter int COOL_CYC   = 100,
  parameter int DOWN_CYC   = 100,
  localparam int AW = $clog2(MAG_SIZE + 1),
  localparam int SW = SPARE_MAGS > 0 ? $clog2(SPARE_MAGS + 1) : 1
) (
  input  logic          sysclk,
  input  logic          reboot,
  input  logic          target_locked,
  input  logic          is_enemy,
  input  logic          fire_command,
  input  logic          overheat_sensor,
  input  logic [1:0]    firing_mode,
  output logic [2:0]    current_state,
  output logic          fire_trigger,
  output logic          criticality_alert,
  output logic [AW-1:0] ammo_count,
  output logic [SW-1:0] spare_count
`ifdef SIGANFU_SHOT_COUNTER_EN
  ,
  output logic [15:0]   shots_total
`endif
);
  localparam int TW = $clog2(max3(RELOAD_CYC, COOL_CYC, DOWN_CYC) + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  state_t state_q, state_d, empty_st;
  logic [AW-1:0] ammo_q, ammo_d;
  logic [SW-1:0] spare_q, spare_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic alert_q, alert_d, fcmd_q;
  logic armed, shooting, more, start, abort, busy, done;
  siganfu_shot_timer #(.PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)) u_timer (
    .clk(sysclk), .rst(reboot), .start(start), .abort(abort),
    .fire(fire_trigger), .busy(busy), .done(done)
  );
  always_comb begin
    armed = is_enemy & target_locked & fire_command;
    shooting = state_q inside {SHOOT_SINGLE, SHOOT_AUTO, SHOOT_BURST};
    empty_st = spare_q != '0 ? RELOAD : DOWNFALL;
    more = ammo_q != '0 && armed &&
           (state_q == SHOOT_AUTO || (state_q == SHOOT_BURST && burst_q < BW'(BURST_LEN)));
    start = shooting && !overheat_sensor && (!busy || (done && more));
    abort = (shooting && overheat_sensor) ||
            !(state_q inside {IDLE, SHOOT_SINGLE, SHOOT_AUTO, RELOAD, OVERHEAT, DOWNFALL, SHOOT_BURST});
    state_d = state_q;
    ammo_d = start ? ammo_q - 1'b1 : ammo_q;
    spare_d = spare_q;
    alert_d = alert_q;
    tmr_d = '0;
    burst_d = start ? burst_q + 1'b1 : burst_q;
    case (state_q)
      IDLE:
        if (armed && ammo_q != '0 && (shoot_state(firing_mode) != SHOOT_SINGLE || !fcmd_q))
          state_d = shoot_state(firing_mode);
      SHOOT_SINGLE, SHOOT_AUTO, SHOOT_BURST:
        if (overheat_sensor) state_d = OVERHEAT;
        else if (done) state_d = ammo_q == '0 ? empty_st : more ? state_q : IDLE;
      RELOAD: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TW'(RELOAD_CYC - 1)) begin
          state_d = IDLE;
          ammo_d = AW'(MAG_SIZE);
          spare_d = spare_q - 1'b1;
          alert_d = alert_q | (spare_q == SW'(1));
        end
      end
      OVERHEAT: begin
        // timer saturates so a long-held sensor still exits on the first clear cycle
        tmr_d = tmr_q == TW'(COOL_CYC - 1) ? tmr_q : tmr_q + 1'b1;
        if (tmr_q == TW'(COOL_CYC - 1) && !overheat_sensor) state_d = ammo_q == '0 ? empty_st : IDLE;
      end
      DOWNFALL: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TW'(DOWN_CYC - 1)) begin
          state_d = IDLE;
          ammo_d = AW'(MAG_SIZE);
          spare_d = SW'(SPARE_MAGS);
          alert_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DOWNFALL) alert_d = 1'b1;
    if (state_d != state_q) tmr_d = '0;
    if (!(state_d inside {SHOOT_SINGLE, SHOOT_AUTO, SHOOT_BURST})) burst_d = '0;
  end
  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state_q <= IDLE;
      ammo_q <= AW'(MAG_SIZE);
      spare_q <= SW'(SPARE_MAGS);
      alert_q <= 1'b0;
      tmr_q <= '0;
      burst_q <= '0;
      fcmd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ammo_q <= ammo_d;
      spare_q <= spare_d;
      alert_q <= alert_d;
      tmr_q <= tmr_d;
      burst_q <= burst_d;
      fcmd_q <= fire_command;
    end
  end
  assign current_state = state_q;
  assign criticality_alert = alert_q;
  assign ammo_count = ammo_q;
  assign spare_count = spare_q;
`ifdef SIGANFU_SHOT_COUNTER_EN
  logic [15:0] shots_q, shots_d;
  assign shots_d = (start && shots_q != 16'hFFFF) ? shots_q + 1'b1 : shots_q;
  always_ff @(posedge sysclk) shots_q <= reboot ? '0 : shots_d;
  assign shots_total = shots_q;
`endif
endmodule

// File: tb/tb_siganfu_weapon_ctrl.sv
// tb_siganfu_weapon_ctrl: directed bench; expected shots queued at stimulus time and checked as pulses appear
module tb_siganfu_weapon_ctrl;
  import siganfu_pkg::*;
  typedef struct { int ammo; int len; } shot_t;
  logic sysclk = 1'b0, reboot = 1'b1, target_locked = 1'b0, is_enemy = 1'b0;
  logic fire_command = 1'b0, fc_s = 1'b0, overheat_sensor = 1'b0;
  logic [1:0] firing_mode = 2'b00;
  logic [2:0] st, st_s, ammo_s;
  logic fire, fire_s, alert, alert_s;
  logic [4:0] ammo;
  logic [1:0] spare;
  logic [0:0] spare_s;
`ifdef SIGANFU_SHOT_COUNTER_EN
  logic [15:0] shots, shots_s;
`endif
  shot_t sb_q[$];
  shot_t exp_shot;
  int checks = 0, failures = 0, pc_s = 0, plen = 0;
  logic prev = 1'b0, prev_s = 1'b0;
  always #5 sysclk = ~sysclk;
  siganfu_weapon_ctrl dut (
    .sysclk(sysclk), .reboot(reboot), .target_locked(target_locked), .is_enemy(is_enemy),
    .fire_command(fire_command), .overheat_sensor(overheat_sensor), .firing_mode(firing_mode),
    .current_state(st), .fire_trigger(fire), .criticality_alert(alert),
    .ammo_count(ammo), .spare_count(spare)
`ifdef SIGANFU_SHOT_COUNTER_EN
    , .shots_total(shots)
`endif
  );
  siganfu_weapon_ctrl #(.MAG_SIZE(4), .SPARE_MAGS(1)) dut_s (
    .sysclk(sysclk), .reboot(reboot), .target_locked(target_locked), .is_enemy(is_enemy),
    .fire_command(fc_s), .overheat_sensor(overheat_sensor), .firing_mode(firing_mode),
    .current_state(st_s), .fire_trigger(fire_s), .criticality_alert(alert_s),
    .ammo_count(ammo_s), .spare_count(spare_s)
`ifdef SIGANFU_SHOT_COUNTER_EN
    , .shots_total(shots_s)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask
  task automatic do_reboot();
    reboot = 1'b1;
    tick(1);
    reboot = 1'b0;
  endtask
  always @(negedge sysclk) begin
    if (fire && !prev) begin
      if (sb_q.size() == 0) chk("sb_spurious_shot", sb_q.size(), 1);
      else begin
        exp_shot = sb_q.pop_front();
        chk("shot_ammo", ammo, exp_shot.ammo);
      end
      plen = 1;
    end else if (fire) plen++;
    else if (prev) chk("pulse_len", plen, exp_shot.len);
    prev = fire;
    if (fire_s && !prev_s) pc_s++;
    prev_s = fire_s;
  end
  initial begin
    int n, base;
    tick(2);
    chk("rst_state", st, IDLE);
    chk("rst_fire", fire, 0);
    chk("rst_alert", alert, 0);
    chk("rst_ammo", ammo, 25);
    chk("rst_spare", spare, 3);
    chk("rst_ammo_s", ammo_s, 4);
    chk("rst_spare_s", spare_s, 1);
    reboot = 1'b0;
    is_enemy = 1'b1;
    target_locked = 1'b1;
    firing_mode = MODE_SINGLE;
    sb_q.push_back('{24, 5});
    fire_command = 1'b1;
    tick(1);
    chk("single_entry", st, SHOOT_SINGLE);
    tick(40);
    chk("single_state", st, IDLE);
    chk("single_ammo", ammo, 24);
    fire_command = 1'b0;
    tick(2);
    sb_q.push_back('{23, 5});
    fire_command = 1'b1;
    tick(20);
    chk("single2_state", st, IDLE);
    chk("single2_ammo", ammo, 23);
    fire_command = 1'b0;
    do_reboot();
    firing_mode = MODE_BURST;
    for (int i = 24; i >= 22; i--) sb_q.push_back('{i, 5});
    fire_command = 1'b1;
    for (int t = 1; t <= 31; t++) begin
      tick(1);
      if (t == 1) chk("burst_entry", st, SHOOT_BURST);
      chk("burst_fire", fire, 32'(t >= 2 && (t - 2) % 10 < 5));
      if (t == 25) fire_command = 1'b0;
    end
    tick(2);
    chk("burst_state", st, IDLE);
    chk("burst_ammo", ammo, 22);
    do_reboot();
    firing_mode = MODE_AUTO;
    base = pc_s;
    fc_s = 1'b1;
    for (n = 0; n < 60 && st_s !== RELOAD; n++) tick(1);
    chk("auto_reach_reload", st_s, RELOAD);
    chk("auto_pulses", pc_s - base, 4);
    chk("reload_ammo0", ammo_s, 0);
    n = 0;
    while (st_s === RELOAD && n < 200) begin tick(1); n++; end
    chk("reload_dwell", n, 50);
    chk("reload_state", st_s, IDLE);
    chk("reload_ammo", ammo_s, 4);
    chk("reload_spare", spare_s, 0);
    chk("reload_alert", alert_s, 1);
    for (n = 0; n < 60 && st_s !== DOWNFALL; n++) tick(1);
    chk("auto_reach_down", st_s, DOWNFALL);
    chk("auto_pulses2", pc_s - base, 8);
    chk("down_alert", alert_s, 1);
    fc_s = 1'b0;
    n = 0;
    while (st_s === DOWNFALL && n < 300) begin tick(1); n++; end
    chk("down_dwell", n, 100);
    chk("down_state", st_s, IDLE);
    chk("down_alert_clr", alert_s, 0);
    chk("down_ammo", ammo_s, 4);
    chk("down_spare", spare_s, 1);
    fc_s = 1'b1;
    for (n = 0; n < 60 && st_s !== RELOAD; n++) tick(1);
    fc_s = 1'b0;
    tick(10);
    chk("rb_in_reload", st_s, RELOAD);
    chk("rb_pre_ammo_s", ammo_s, 0);
    do_reboot();
    chk("rb_state_s", st_s, IDLE);
    chk("rb_ammo_s", ammo_s, 4);
    chk("rb_spare_s", spare_s, 1);
    chk("rb_alert_s", alert_s, 0);
    do_reboot();
    sb_q.push_back('{24, 3});
    fire_command = 1'b1;
    tick(1);
    chk("auto_entry", st, SHOOT_AUTO);
    tick(3);
    overheat_sensor = 1'b1;
    tick(1);
    chk("ovh_fire", fire, 0);
    chk("ovh_state", st, OVERHEAT);
    chk("ovh_ammo", ammo, 24);
    fire_command = 1'b0;
    tick(120);
    chk("ovh_hold", st, OVERHEAT);
    overheat_sensor = 1'b0;
    tick(1);
    chk("ovh_exit", st, IDLE);
    sb_q.push_back('{23, 3});
    fire_command = 1'b1;
    tick(4);
    overheat_sensor = 1'b1;
    tick(1);
    chk("ovh2_state", st, OVERHEAT);
    overheat_sensor = 1'b0;
    fire_command = 1'b0;
    n = 0;
    while (st === OVERHEAT && n < 300) begin tick(1); n++; end
    chk("ovh_dwell", n, 100);
    chk("ovh2_exit", st, IDLE);
    chk("ovh2_ammo", ammo, 23);
    do_reboot();
    sb_q.push_back('{24, 2});
    fire_command = 1'b1;
    tick(3);
    chk("rb_mid_fire", fire, 1);
    reboot = 1'b1;
    tick(1);
    reboot = 1'b0;
    chk("rb_fire", fire, 0);
    chk("rb_state", st, IDLE);
    chk("rb_ammo", ammo, 25);
    chk("rb_spare", spare, 3);
    chk("rb_alert", alert, 0);
    sb_q.push_back('{24, 5});
    tick(3);
    #1 reboot = 1'b1;
    #2 reboot = 1'b0;
    tick(1);
    chk("glitch_fire", fire, 1);
    chk("glitch_state", st, SHOOT_AUTO);
    chk("glitch_ammo", ammo, 24);
    fire_command = 1'b0;
    tick(20);
    chk("glitch_end_state", st, IDLE);
    chk("glitch_end_ammo", ammo, 24);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
